// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle for the digit-serial BCD-to-binary converter.
// Handshake: a request is taken on the rising edge where ready=1 and start=1; done pulses one cycle when bin_out/err are fresh.
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  ready,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output ready,
    output busy,
    output done,
    output bin_out,
    output err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Digit-serial BCD-to-binary converter: Horner's rule (acc = acc*10 + digit), MSD first, one digit per clock.
// Any digit above 9 flags err and forces the result to zero without changing the cycle count.
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic         clk,
  input  logic         rst,
  bcd2bin_seq_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [4*DIGITS-1:0] r_shift;
  logic [BIN_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_acc;
  logic [BIN_W-1:0]    r_bin_out;
  logic                r_err;

  logic                w_accept;
  logic                w_last;
  logic [3:0]          w_digit;
  logic [BIN_W-1:0]    w_acc_x8;
  logic [BIN_W-1:0]    w_acc_x2;
  logic [BIN_W-1:0]    w_acc_next;
  logic                w_err_next;

  // The MSD always sits at the top of the shift register; it moves up one digit per step.
  assign w_digit    = r_shift[4*DIGITS-1 -: 4];
  assign w_acc_x8   = r_acc << 3;
  assign w_acc_x2   = r_acc << 1;
  assign w_acc_next = w_acc_x8 + w_acc_x2 + BIN_W'(w_digit);
  assign w_err_next = r_err_acc | (w_digit > 4'd9);
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_accept   = (r_state != S_CONV) && bus.start;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next_state = S_CONV;
      S_CONV: if (w_last)    w_next_state = S_DONE;
      S_DONE: w_next_state = bus.start ? S_CONV : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err_acc <= 1'b0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= bus.bcd_in;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err_acc <= 1'b0;
    end else if (r_state == S_CONV) begin
      r_shift   <= r_shift << 4;
      r_acc     <= w_acc_next;
      r_cnt     <= r_cnt + 1'b1;
      r_err_acc <= w_err_next;
      // Results only move on the completing edge so they stay stable between conversions.
      if (w_last) begin
        r_bin_out <= w_err_next ? '0 : w_acc_next;
        r_err     <= w_err_next;
      end
    end
  end

  assign bus.ready   = (r_state != S_CONV);
  assign bus.busy    = (r_state == S_CONV);
  assign bus.done    = (r_state == S_DONE);
  assign bus.bin_out = r_bin_out;
  assign bus.err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: a digit-weighted reference model scored every cycle, plus literal result checks.
module tb_bcd2bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int W      = 4 * DIGITS;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) intf ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (intf.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: weighted sum of decimal digits, err if any digit exceeds 9.
  function automatic logic [BIN_W:0] ref_conv(input logic [W-1:0] b);
    int unsigned val;
    int unsigned pw;
    bit          bad;
    val = 0;
    pw  = 1;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      int unsigned d;
      d = b[4*k +: 4];
      if (d > 9) bad = 1'b1;
      val += d * pw;
      pw  *= 10;
    end
    return bad ? {1'b1, {BIN_W{1'b0}}} : {1'b0, BIN_W'(val)};
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [BIN_W:0]   exp_q[$];
  bit               m_init = 1'b0;
  int               m_rem  = 0;
  bit               m_done = 1'b0;
  bit               m_acc  = 1'b0;
  logic [BIN_W-1:0] m_bin  = '0;
  bit               m_err  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_rem  = 0;
      m_done = 1'b0;
      m_bin  = '0;
      m_err  = 1'b0;
      exp_q.delete();
    end else if (m_init) begin
      m_acc  = (m_rem == 0) && (intf.start === 1'b1);
      m_done = 1'b0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          {m_err, m_bin} = exp_q.pop_front();
          m_done = 1'b1;
        end
      end
      if (m_acc) begin
        exp_q.push_back(ref_conv(intf.bcd_in));
        m_rem = DIGITS;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready",   32'(intf.ready),   32'(m_rem == 0));
      chk("busy",    32'(intf.busy),    32'(m_rem != 0));
      chk("done",    32'(intf.done),    32'(m_done));
      chk("bin_out", 32'(intf.bin_out), 32'(m_bin));
      chk("err",     32'(intf.err),     32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with ready=1; returns at the negedge after the accepting edge.
  task automatic start_conv(input logic [W-1:0] bcd);
    intf.start  = 1'b1;
    intf.bcd_in = bcd;
    @(negedge clk);
    intf.start  = 1'b0;
    intf.bcd_in = W'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (intf.done === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_done: no done within %0d cycles", n);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] bcd,
                         input int exp_bin, input bit exp_err);
    int n;
    start_conv(bcd);
    wait_done(n);
    chk({name, "_latency"}, 32'(n + 1), 32'(DIGITS + 1));
    chk({name, "_bin"},     32'(intf.bin_out), 32'(exp_bin));
    chk({name, "_err"},     32'(intf.err),     32'(exp_err));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    intf.start  = 1'b0;
    intf.bcd_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(intf.ready),   32'd1);
    chk("rst_busy",  32'(intf.busy),    32'd0);
    chk("rst_done",  32'(intf.done),    32'd0);
    chk("rst_bin",   32'(intf.bin_out), 32'd0);
    chk("rst_err",   32'(intf.err),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one("h1234", 16'h1234, 1234, 1'b0);
    @(negedge clk);
    run_one("h9999", 16'h9999, 9999, 1'b0);
    @(negedge clk);
    run_one("h0000", 16'h0000, 0, 1'b0);
    @(negedge clk);
    run_one("h12A4", 16'h12A4, 0, 1'b1);
    @(negedge clk);
    run_one("h0007", 16'h0007, 7, 1'b0);
    @(negedge clk);
    run_one("hF000", 16'hF000, 0, 1'b1);
    // back-to-back straight from the DONE cycle
    run_one("h0809_b2b", 16'h0809, 809, 1'b0);
    @(negedge clk);

    // start pulsed while busy must be ignored
    start_conv(16'h0042);
    intf.start  = 1'b1;
    intf.bcd_in = 16'h9999;
    @(negedge clk);
    intf.start  = 1'b0;
    wait_done(n);
    chk("ign_latency", 32'(n + 2), 32'(DIGITS + 1));
    chk("ign_bin",     32'(intf.bin_out), 32'd42);
    chk("ign_err",     32'(intf.err),     32'd0);
    // start held in the DONE cycle
    run_one("h0500_b2b", 16'h0500, 500, 1'b0);
    @(negedge clk);

    // reset during the second CONV cycle aborts the conversion
    start_conv(16'h8888);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bin",   32'(intf.bin_out), 32'd0);
    chk("abort_ready", 32'(intf.ready),   32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(intf.done), 32'd0);
    end
    run_one("h0001", 16'h0001, 1, 1'b0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
